// File: rtl/pkg_en.sv
// Shared types and constants for the ElectronNest stream engine.
// Tokens, op codes, FSM states and the per-word ALU.
package pkg_en;

   localparam int WIDTH_DATA   = 32;
   localparam int WIDTH_EXADDR = 32;
   localparam int WIDTH_INDEX  = 32;
   localparam int BOOT_WORDS   = 8;

   typedef struct packed {
      logic                   v;
      logic                   a;
      logic                   r;
      logic                   c;
      logic [WIDTH_INDEX-1:0] i;
      logic [WIDTH_DATA-1:0]  d;
   } FTk_t;

   typedef struct packed {
      logic n;
      logic t;
      logic v;
      logic c;
   } BTk_t;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_ADD  = 4'd1,
      OP_XOR  = 4'd2,
      OP_SHL  = 4'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BOOT,
      ST_RUN,
      ST_DRAIN
   } state_e;

   // Unlisted op codes fall through to pass.
   function automatic logic [WIDTH_DATA-1:0] f_alu(
      input logic [3:0]            op,
      input logic [WIDTH_DATA-1:0] d,
      input logic [15:0]           imm
   );
      logic [WIDTH_DATA-1:0] w_imm;
      logic [WIDTH_DATA-1:0] w_res;
      w_imm = {{(WIDTH_DATA-16){imm[15]}}, imm};
      unique case (1'b1)
         (op == OP_ADD): w_res = d + w_imm;
         (op == OP_XOR): w_res = d ^ w_imm;
         (op == OP_SHL): w_res = d << imm[4:0];
         default:        w_res = d;
      endcase
      return w_res;
   endfunction

endpackage

// File: rtl/en_result_fifo.sv
// Result FIFO between the ALU and the store port.
// Push while full is honoured only together with a pop.
module en_result_fifo
   import pkg_en::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [WIDTH_DATA-1:0] i_data,
   output logic [WIDTH_DATA-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH_DATA-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wp;
   logic [AW-1:0]         r_rp;
   logic [AW:0]           r_count;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rp];
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

endmodule

// File: rtl/electron_nest.sv
// ElectronNest compute node: boot-configured load -> ALU -> store stream engine.
// Loads have a fixed one-cycle return latency; the FIFO bounds outstanding loads.
module electron_nest
   import pkg_en::*;
#(
   parameter int DEPTH_FIFO = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    I_Boot,
   output logic                    O_Ld_Req,
   output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
   input  FTk_t                    I_Ld_FTk,
   output BTk_t                    O_Ld_BTk,
   output logic                    O_St_Req,
   output logic [WIDTH_EXADDR-1:0] O_St_Addr,
   output FTk_t                    O_St_FTk,
   input  BTk_t                    I_St_BTk
);

   localparam int CW = $clog2(DEPTH_FIFO) + 1;

   state_e                  r_state;
   state_e                  w_next;
   logic [3:0]              r_idx;
   logic [WIDTH_EXADDR-1:0] r_ld_base;
   logic [31:0]             r_count;
   logic [WIDTH_EXADDR-1:0] r_st_base;
   logic [WIDTH_EXADDR-1:0] r_st_stride;
   logic [WIDTH_DATA-1:0]   r_opw;
   logic [31:0]             r_issued;
   logic [31:0]             r_stored;
   logic                    r_inflight;

   logic                    w_cap;
   logic [3:0]              w_bidx;
   logic                    w_ld_ret;
   logic                    w_st_acc;
   logic [WIDTH_DATA-1:0]   w_alu;
   logic [WIDTH_DATA-1:0]   w_head;
   logic                    w_full;
   logic                    w_empty;
   logic [CW-1:0]           w_occ;
   logic                    w_unused;

   assign w_cap    = (r_state == ST_BOOT) && I_Ld_FTk.v;
   assign w_bidx   = I_Ld_FTk.a ? 4'd0 : r_idx;
   assign w_ld_ret = I_Ld_FTk.v && r_inflight;
   assign w_st_acc = O_St_Req && !I_St_BTk.n;
   assign w_alu    = f_alu(r_opw[31:28], I_Ld_FTk.d, r_opw[15:0]);
   assign w_unused = ^{I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i,
                       I_St_BTk.t, I_St_BTk.v, I_St_BTk.c, r_opw[27:16]};

   en_result_fifo #(.DEPTH(DEPTH_FIFO)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_ld_ret),
      .i_pop   (w_st_acc),
      .i_data  (w_alu),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (I_Boot) w_next = ST_BOOT;
         ST_BOOT:  if (r_idx == 4'(BOOT_WORDS) && !I_Boot)
                      w_next = (r_count == '0) ? ST_IDLE : ST_RUN;
         ST_RUN:   if (r_issued == r_count) w_next = ST_DRAIN;
         ST_DRAIN: if (r_stored == r_count) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      O_Ld_Req  = (r_state == ST_RUN) && (r_issued < r_count) &&
                  ((w_occ + CW'(r_inflight)) < CW'(DEPTH_FIFO));
      O_Ld_Addr = r_ld_base + r_issued;
      O_Ld_BTk   = '0;
      O_Ld_BTk.n = w_full;
      O_St_Req  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_empty;
      O_St_Addr = r_st_base + r_stored * r_st_stride;
      O_St_FTk   = '0;
      O_St_FTk.v = O_St_Req;
      O_St_FTk.i = r_stored;
      O_St_FTk.d = O_St_Req ? w_head : '0;
   end

   // Header words 0..2 only advance the index.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_idx       <= '0;
         r_ld_base   <= '0;
         r_count     <= '0;
         r_st_base   <= '0;
         r_st_stride <= '0;
         r_opw       <= '0;
         r_issued    <= '0;
         r_stored    <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_inflight <= O_Ld_Req;
         if (O_Ld_Req) r_issued <= r_issued + 32'd1;
         if (w_st_acc) r_stored <= r_stored + 32'd1;
         if (r_state == ST_IDLE && I_Boot) begin
            r_idx    <= '0;
            r_issued <= '0;
            r_stored <= '0;
         end
         if (w_cap && w_bidx < 4'(BOOT_WORDS)) begin
            r_idx <= w_bidx + 4'd1;
            unique case (w_bidx)
               4'd3:    r_ld_base   <= I_Ld_FTk.d;
               4'd4:    r_count     <= I_Ld_FTk.d;
               4'd5:    r_st_base   <= I_Ld_FTk.d;
               4'd6:    r_st_stride <= I_Ld_FTk.d;
               4'd7:    r_opw       <= I_Ld_FTk.d;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_electron_nest.sv
// Randomized bench for electron_nest against a word-level stream model.
// Memory responder and store scoreboard share one driver process.
module tb_electron_nest;
   import pkg_en::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        I_Boot = 1'b0;
   logic        O_Ld_Req;
   logic [31:0] O_Ld_Addr;
   FTk_t        I_Ld_FTk = '0;
   BTk_t        O_Ld_BTk;
   logic        O_St_Req;
   logic [31:0] O_St_Addr;
   FTk_t        O_St_FTk;
   BTk_t        I_St_BTk = '0;

   always #5 clock = ~clock;

   electron_nest #(.DEPTH_FIFO(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .I_Boot    (I_Boot),
      .O_Ld_Req  (O_Ld_Req),
      .O_Ld_Addr (O_Ld_Addr),
      .I_Ld_FTk  (I_Ld_FTk),
      .O_Ld_BTk  (O_Ld_BTk),
      .O_St_Req  (O_St_Req),
      .O_St_Addr (O_St_Addr),
      .O_St_FTk  (O_St_FTk),
      .I_St_BTk  (I_St_BTk)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   logic [31:0] mem [logic [31:0]];
   FTk_t        boot_q [$];
   logic [31:0] exp_a [$];
   logic [31:0] exp_d [$];
   int          st_cnt = 0;
   int          ld_cnt = 0;
   int          ldreq_seen = 0;
   int          streq_seen = 0;
   int          bound_err = 0;
   int          bp_hold = 0;
   bit          bp_rand = 0;
   bit          pend = 0;
   logic [31:0] pend_a = '0;
   bit          prev_stall = 0;
   logic [31:0] prev_a = '0;
   logic [31:0] prev_d = '0;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   function automatic logic [31:0] model(input int op, input logic [31:0] d,
                                         input logic [15:0] imm);
      int si;
      si = int'(signed'(imm));
      case (op)
         1:       return d + 32'(si);
         2:       return d ^ 32'(si);
         3:       return d << imm[4:0];
         default: return d;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (pend) begin
            I_Ld_FTk   = '0;
            I_Ld_FTk.v = 1'b1;
            I_Ld_FTk.d = rd(pend_a);
         end else if (boot_q.size() > 0) begin
            I_Ld_FTk = boot_q.pop_front();
         end else begin
            I_Ld_FTk = '0;
         end
         I_St_BTk = '0;
         if (bp_hold > 0) begin
            I_St_BTk.n = 1'b1;
            bp_hold--;
         end else if (bp_rand) begin
            I_St_BTk.n = ($urandom_range(0, 2) == 0);
         end
         @(negedge clock);
         if (!reset) ld_cnt = st_cnt;
         if (prev_stall) begin
            chk("hold_addr", O_St_Addr, prev_a);
            chk("hold_data", O_St_FTk.d, prev_d);
         end
         pend   = O_Ld_Req;
         pend_a = O_Ld_Addr;
         if (O_Ld_Req) begin
            ldreq_seen++;
            if (ld_cnt - st_cnt >= DEPTH) bound_err++;
            ld_cnt++;
         end
         if (O_St_Req) streq_seen++;
         prev_stall = O_St_Req && I_St_BTk.n;
         prev_a     = O_St_Addr;
         prev_d     = O_St_FTk.d;
         if (O_St_Req && !I_St_BTk.n) begin
            if (exp_a.size() == 0) begin
               chk("st_extra", 32'd1, 32'd0);
            end else begin
               chk("st_addr", O_St_Addr, exp_a.pop_front());
               chk("st_data", O_St_FTk.d, exp_d.pop_front());
            end
            st_cnt++;
         end
      end
   end

   int st0;

   task automatic do_boot(input logic [31:0] ldb, input logic [31:0] cnt,
                          input logic [31:0] stb, input logic [31:0] str,
                          input logic [31:0] opw, input bit gaps);
      logic [31:0] w [8];
      FTk_t        t;
      int          g;
      w = '{32'hA5A5_0001, 32'd0, 32'd0, ldb, cnt, stb, str, opw};
      for (int k = 0; k < int'(cnt); k++) begin
         exp_a.push_back(stb + 32'(k) * str);
         exp_d.push_back(model(int'(opw[31:28]), rd(ldb + 32'(k)), opw[15:0]));
      end
      st0        = st_cnt;
      ldreq_seen = 0;
      streq_seen = 0;
      bound_err  = 0;
      @(negedge clock);
      I_Boot = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            t   = '0;
            t.a = 1'($urandom);
            t.d = $urandom;
            boot_q.push_back(t);
         end
         t   = '0;
         t.v = 1'b1;
         t.a = (i == 0);
         t.d = w[i];
         boot_q.push_back(t);
      end
      g = 0;
      while (boot_q.size() > 0 && g < 100) begin
         @(negedge clock);
         g++;
      end
      @(negedge clock);
      I_Boot = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int cnt);
      int g;
      g = 0;
      while ((st_cnt - st0 < cnt || dut.r_state != ST_IDLE) && g < 2000) begin
         @(negedge clock);
         g++;
      end
      chk({tag, "_timeout"}, 32'(g < 2000), 32'd1);
      chk({tag, "_nstores"}, 32'(st_cnt - st0), 32'(cnt));
      chk({tag, "_idle"}, 32'(dut.r_state), 32'(ST_IDLE));
      chk({tag, "_left"}, 32'(exp_a.size()), 32'd0);
      chk({tag, "_bound"}, 32'(bound_err), 32'd0);
   endtask

   task automatic wait_stores(input int n);
      int g;
      g = 0;
      while (st_cnt - st0 < n && g < 500) begin
         @(negedge clock);
         g++;
      end
      chk("wait_stores", 32'(g < 500), 32'd1);
   endtask

   initial begin
      logic [31:0] ldb, stb, opw;
      int          cnt, str;
      repeat (3) @(negedge clock);
      chk("rst_ldreq", 32'(O_Ld_Req), 32'd0);
      chk("rst_ldaddr", O_Ld_Addr, 32'd0);
      chk("rst_ldbtk", 32'(O_Ld_BTk), 32'd0);
      chk("rst_streq", 32'(O_St_Req), 32'd0);
      chk("rst_staddr", O_St_Addr, 32'd0);
      chk("rst_stftk", 32'(O_St_FTk != '0), 32'd0);
      chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
      reset = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 4; i++) mem[32'h10 + 32'(i)] = 32'(i + 1);
      do_boot(32'h10, 32'd4, 32'h20, 32'd1, 32'h1000_0005, 1'b0);
      wait_done("t1", 4);

      mem[32'h40] = 32'h0F;
      do_boot(32'h40, 32'd3, 32'h80, 32'd2, 32'h2000_00FF, 1'b0);
      wait_done("t2", 3);

      do_boot(32'h100, 32'd12, 32'h200, 32'd1, 32'h3000_0004, 1'b0);
      wait_stores(2);
      bp_hold = 10;
      repeat (8) @(negedge clock);
      chk("bp_full", 32'(O_Ld_BTk.n), 32'd1);
      chk("bp_noreq", 32'(O_Ld_Req), 32'd0);
      chk("bp_stall", 32'(O_St_Req), 32'd1);
      wait_done("t3", 12);

      do_boot(32'h300, 32'd0, 32'h380, 32'd1, 32'h1000_0001, 1'b0);
      wait_done("t4", 0);
      chk("t4_ldreq", 32'(ldreq_seen), 32'd0);
      chk("t4_streq", 32'(streq_seen), 32'd0);

      do_boot(32'h400, 32'd20, 32'h500, 32'd1, 32'h1000_0001, 1'b0);
      wait_stores(3);
      #2 reset = 1'b0;
      #1;
      chk("t5_ldreq", 32'(O_Ld_Req), 32'd0);
      chk("t5_ldaddr", O_Ld_Addr, 32'd0);
      chk("t5_ldbtk", 32'(O_Ld_BTk), 32'd0);
      chk("t5_streq", 32'(O_St_Req), 32'd0);
      chk("t5_staddr", O_St_Addr, 32'd0);
      chk("t5_stftk", 32'(O_St_FTk != '0), 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      exp_a.delete();
      exp_d.delete();
      ldreq_seen = 0;
      streq_seen = 0;
      repeat (10) @(negedge clock);
      chk("t5_noreq", 32'(ldreq_seen + streq_seen), 32'd0);
      chk("t5_idle", 32'(dut.r_state), 32'(ST_IDLE));

      do_boot(32'h10, 32'd4, 32'h20, 32'd1, 32'h1000_0005, 1'b1);
      wait_done("t6", 4);

      bp_rand = 1;
      for (int r = 0; r < 8; r++) begin
         ldb = (r == 0) ? 32'hFFFF_FFFE : $urandom;
         stb = (r == 1) ? 32'hFFFF_FFFD : $urandom;
         cnt = $urandom_range(1, 12);
         str = $urandom_range(0, 5);
         opw = {4'($urandom_range(0, 7)), 12'($urandom), 16'($urandom)};
         do_boot(ldb, 32'(cnt), stb, 32'(str), opw, 1'($urandom));
         wait_done("rnd", cnt);
      end
      bp_rand = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
